// File: rtl/mem_access_pkg.sv
// Shared encodings for the memory-access stage: writeback sources, load/store
// sizes, FSM states and the access legality check.
package mem_access_pkg;

  // Writeback source select
  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;
  localparam logic [1:0] WB_CSR = 2'd3;

  // Load sizes (funct3)
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  // Store sizes (funct3)
  localparam logic [2:0] SB = 3'b000;
  localparam logic [2:0] SH = 3'b001;
  localparam logic [2:0] SW = 3'b010;

  typedef enum logic {
    MA_IDLE   = 1'b0,
    MA_WAIT_R = 1'b1
  } ma_state_e;

  // True when a memory op must be suppressed: illegal size for the op type,
  // or a halfword/word that is not naturally aligned.
  function automatic logic access_bad(input logic       is_store,
                                      input logic [2:0] funct3,
                                      input logic [1:0] addr_lo);
    logic illegal;
    logic misal;
    if (is_store) illegal = (funct3 > SW);
    else          illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
    case (funct3[1:0])
      2'b01:   misal = addr_lo[0];
      2'b10:   misal = (addr_lo != 2'b00);
      default: misal = 1'b0;
    endcase
    return illegal || misal;
  endfunction

endpackage

// File: rtl/mem_access_load_align.sv
// Picks the addressed byte/halfword out of a read word and extends it.
module load_align
  import mem_access_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane selection and sign/zero extension
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned and a latch is never inferred.
    byte_sel = rdata[7:0];
    data     = rdata;
    case (addr_lo)
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      2'd3:    byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      LB:      data = {{24{byte_sel[7]}}, byte_sel};
      LH:      data = {{16{half_sel[15]}}, half_sel};
      LBU:     data = {24'd0, byte_sel};
      LHU:     data = {16'd0, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// Memory-access stage: data-bus master, store lane steering, load formatting,
// upstream stall and the registers toward writeback.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       alu_in,
  input  logic [31:0]       rs2_in,
  input  logic [4:0]        rd_addr_in,
  input  logic              reg_write_in,
  input  logic              mem_write_in,
  input  logic [2:0]        funct3_in,
  input  logic [1:0]        wb_mux_in,
  output logic [ADDR_W-1:0] dbus_addr,
  output logic [31:0]       dbus_wdata,
  output logic [3:0]        dbus_wstrb,
  output logic              dbus_we,
  output logic              dbus_valid,
  input  logic              dbus_ready,
  input  logic              dbus_rvalid,
  input  logic [31:0]       dbus_rdata,
  output logic              stall,
  output logic [31:0]       fwd_mem,
  output logic              misalign,
  output logic [4:0]        rd_addr_out,
  output logic              reg_write_out,
  output logic [1:0]        wb_mux_out,
  output logic [31:0]       alu_out,
  output logic [31:0]       load_data_out
);

  ma_state_e   state;
  ma_state_e   state_nx;
  logic        is_store;
  logic        is_load;
  logic        mem_op;
  logic        bad;
  logic        load_done;
  logic [31:0] load_fmt;

  assign is_store  = mem_write_in;
  assign is_load   = !mem_write_in && (wb_mux_in == WB_MEM);
  assign mem_op    = is_store || is_load;
  assign bad       = mem_op && access_bad(is_store, funct3_in, alu_in[1:0]);
  assign fwd_mem   = alu_in;
  assign dbus_addr = {alu_in[ADDR_W-1:2], 2'b00};
  assign dbus_we   = dbus_valid && is_store;

  load_align u_load_align (
    .rdata   (dbus_rdata),
    .addr_lo (alu_in[1:0]),
    .funct3  (funct3_in),
    .data    (load_fmt)
  );

  // Store data replication and byte strobes; strobes stay zero for non-stores
  always_comb begin
    dbus_wdata = rs2_in;
    dbus_wstrb = 4'b0000;
    case (funct3_in)
      SB: begin
        dbus_wdata = {4{rs2_in[7:0]}};
        dbus_wstrb = 4'b0001 << alu_in[1:0];
      end
      SH: begin
        dbus_wdata = {2{rs2_in[15:0]}};
        dbus_wstrb = 4'b0011 << alu_in[1:0];
      end
      default: begin
        dbus_wdata = rs2_in;
        dbus_wstrb = 4'b1111;
      end
    endcase
    if (!is_store) dbus_wstrb = 4'b0000;
  end

  // Next state, bus request, stall and misalign; all forced idle in reset so
  // the pipeline is released as soon as rst_n drops
  always_comb begin
    state_nx   = state;
    dbus_valid = 1'b0;
    stall      = 1'b0;
    misalign   = 1'b0;
    load_done  = 1'b0;
    if (rst_n) begin
      unique case (state)
        MA_IDLE: begin
          if (mem_op) begin
            if (bad) begin
              misalign = 1'b1;
            end else begin
              dbus_valid = 1'b1;
              if (!dbus_ready) begin
                stall = 1'b1;
              end else if (is_load) begin
                stall    = 1'b1;
                state_nx = MA_WAIT_R;
              end
            end
          end
        end
        MA_WAIT_R: begin
          if (dbus_rvalid) begin
            load_done = 1'b1;
            state_nx  = MA_IDLE;
          end else begin
            stall = 1'b1;
          end
        end
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples values from before the edge, independent of block ordering.
    if (!rst_n) state <= MA_IDLE;
    else        state <= state_nx;
  end

  // Writeback registers: bubble while stalled, otherwise the current op
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: only these few pipeline registers are reset; there is no storage
    // array here that would need (or could afford) a reset.
    if (!rst_n) begin
      rd_addr_out   <= '0;
      reg_write_out <= 1'b0;
      wb_mux_out    <= '0;
      alu_out       <= '0;
      load_data_out <= '0;
    end else if (stall) begin
      rd_addr_out   <= '0;
      reg_write_out <= 1'b0;
      wb_mux_out    <= '0;
      alu_out       <= '0;
      load_data_out <= '0;
    end else begin
      rd_addr_out   <= rd_addr_in;
      reg_write_out <= reg_write_in && !bad;
      wb_mux_out    <= wb_mux_in;
      alu_out       <= alu_in;
      load_data_out <= load_done ? load_fmt : 32'd0;
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: directed ops push expected bus and
// writeback records; monitors pop and compare as the DUT presents them.
module tb_mem_access;
  import mem_access_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] alu_in = '0;
  logic [31:0] rs2_in = '0;
  logic [4:0]  rd_addr_in = '0;
  logic        reg_write_in = 1'b0;
  logic        mem_write_in = 1'b0;
  logic [2:0]  funct3_in = '0;
  logic [1:0]  wb_mux_in = '0;
  logic [31:0] dbus_addr;
  logic [31:0] dbus_wdata;
  logic [3:0]  dbus_wstrb;
  logic        dbus_we;
  logic        dbus_valid;
  logic        dbus_ready = 1'b0;
  logic        dbus_rvalid = 1'b0;
  logic [31:0] dbus_rdata = '0;
  logic        stall;
  logic [31:0] fwd_mem;
  logic        misalign;
  logic [4:0]  rd_addr_out;
  logic        reg_write_out;
  logic [1:0]  wb_mux_out;
  logic [31:0] alu_out;
  logic [31:0] load_data_out;

  mem_access #(.ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .alu_in(alu_in), .rs2_in(rs2_in),
    .rd_addr_in(rd_addr_in), .reg_write_in(reg_write_in),
    .mem_write_in(mem_write_in), .funct3_in(funct3_in), .wb_mux_in(wb_mux_in),
    .dbus_addr(dbus_addr), .dbus_wdata(dbus_wdata), .dbus_wstrb(dbus_wstrb),
    .dbus_we(dbus_we), .dbus_valid(dbus_valid), .dbus_ready(dbus_ready),
    .dbus_rvalid(dbus_rvalid), .dbus_rdata(dbus_rdata), .stall(stall),
    .fwd_mem(fwd_mem), .misalign(misalign), .rd_addr_out(rd_addr_out),
    .reg_write_out(reg_write_out), .wb_mux_out(wb_mux_out),
    .alu_out(alu_out), .load_data_out(load_data_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic        rw;
    logic [1:0]  wb;
    logic [31:0] alu;
    logic [31:0] ld;
  } wb_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  strb;
    logic [31:0] wdata;
  } bus_t;

  wb_t  wb_q[$];
  bus_t bus_q[$];
  int   n_pass = 0;
  int   n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Writeback monitor: any non-bubble register contents is one retired op
  always @(negedge clk) begin
    wb_t e;
    if (rst_n && ({rd_addr_out, reg_write_out, wb_mux_out, alu_out, load_data_out} != '0)) begin
      if (wb_q.size() == 0) begin
        n_total++;
        $display("FAIL wb_unexpected: got alu_out %h with empty queue", alu_out);
      end else begin
        e = wb_q.pop_front();
        check("wb_rd", 32'(rd_addr_out), 32'(e.rd));
        check("wb_reg_write", 32'(reg_write_out), 32'(e.rw));
        check("wb_mux", 32'(wb_mux_out), 32'(e.wb));
        check("wb_alu", alu_out, e.alu);
        check("wb_load_data", load_data_out, e.ld);
      end
    end
  end

  // Bus monitor: every accepted request must match the next expected one
  always @(negedge clk) begin
    bus_t b;
    if (dbus_valid && dbus_ready) begin
      if (bus_q.size() == 0) begin
        n_total++;
        $display("FAIL bus_unexpected: got request addr %h with empty queue", dbus_addr);
      end else begin
        b = bus_q.pop_front();
        check("bus_addr", dbus_addr, b.addr);
        check("bus_we", 32'(dbus_we), 32'(b.we));
        check("bus_wstrb", 32'(dbus_wstrb), 32'(b.strb));
        if (b.we) check("bus_wdata", dbus_wdata, b.wdata);
      end
    end
  end

  task automatic drive_nop();
    alu_in = '0; rs2_in = '0; rd_addr_in = '0; reg_write_in = 1'b0;
    mem_write_in = 1'b0; funct3_in = '0; wb_mux_in = WB_ALU;
    dbus_ready = 1'b0; dbus_rvalid = 1'b0;
  endtask

  // Present one op, play the bus with the given delays, then count stall and
  // misalign cycles against the hand-computed expectations.
  task automatic issue(input string name, input logic we, input logic [2:0] f3,
                       input logic [1:0] wbm, input logic [4:0] rd, input logic rw,
                       input logic [31:0] alu, input logic [31:0] rs2,
                       input int rdy_wait, input int rv_wait, input logic [31:0] rdata,
                       input bit exp_bus, input logic [3:0] exp_strb,
                       input logic [31:0] exp_wdata, input logic exp_rw,
                       input logic [31:0] exp_ld, input int exp_stall, input int exp_mis);
    int cyc = 0;
    int since = 0;
    int stalls = 0;
    int mis = 0;
    bit accepted = 0;
    bit done = 0;
    wb_t  w;
    bus_t b;
    w.rd = rd; w.rw = exp_rw; w.wb = wbm; w.alu = alu; w.ld = exp_ld;
    wb_q.push_back(w);
    if (exp_bus) begin
      b.addr = {alu[31:2], 2'b00}; b.we = we; b.strb = exp_strb; b.wdata = exp_wdata;
      bus_q.push_back(b);
    end
    alu_in = alu; rs2_in = rs2; rd_addr_in = rd; reg_write_in = rw;
    mem_write_in = we; funct3_in = f3; wb_mux_in = wbm; dbus_rdata = rdata;
    while (!done && cyc < 50) begin
      dbus_ready  = !accepted && (cyc >= rdy_wait);
      dbus_rvalid = accepted && (since == rv_wait);
      @(negedge clk);
      if (cyc == 0) check({name, "_fwd"}, fwd_mem, alu);
      if (stall) stalls++;
      if (misalign) mis++;
      if (!stall) done = 1;
      if (dbus_valid && dbus_ready) begin
        accepted = 1;
        since = 0;
      end
      @(posedge clk); #1;
      cyc++;
      if (accepted) since++;
    end
    drive_nop();
    if (!done) begin
      n_total++;
      $display("FAIL %s_timeout: stall still high after %0d cycles", name, cyc);
    end
    check({name, "_stall_cycles"}, 32'(stalls), 32'(exp_stall));
    check({name, "_misalign_cycles"}, 32'(mis), 32'(exp_mis));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    drive_nop();
    repeat (2) @(posedge clk);
    #1;
    check("reset_stall", 32'(stall), 32'd0);
    check("reset_valid", 32'(dbus_valid), 32'd0);
    check("reset_reg_write", 32'(reg_write_out), 32'd0);
    check("reset_alu_out", alu_out, 32'd0);
    check("reset_load_data", load_data_out, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    //    name    we  f3   wb      rd     rw  alu           rs2           rdy rv rdata         bus strb     wdata         exp_rw ld           stl mis
    issue("alu",  0, 3'b000, WB_ALU, 5'd5,  1, 32'h0000_1234, 32'h0,        0, 0, 32'h0,        0, 4'h0,    32'h0,        1, 32'h0,        0, 0);
    issue("sw",   1, SW,  WB_ALU, 5'd0,  0, 32'h0000_0100, 32'hDEAD_BEEF, 0, 0, 32'h0,        1, 4'b1111, 32'hDEAD_BEEF, 0, 32'h0,        0, 0);
    issue("sb",   1, SB,  WB_ALU, 5'd0,  0, 32'h0000_0103, 32'h0000_00A5, 0, 0, 32'h0,        1, 4'b1000, 32'hA5A5_A5A5, 0, 32'h0,        0, 0);
    issue("sh",   1, SH,  WB_ALU, 5'd0,  0, 32'h0000_0102, 32'h1234_BEEF, 0, 0, 32'h0,        1, 4'b1100, 32'hBEEF_BEEF, 0, 32'h0,        0, 0);
    issue("sw_w", 1, SW,  WB_ALU, 5'd0,  0, 32'h0000_0104, 32'h0102_0304, 2, 0, 32'h0,        1, 4'b1111, 32'h0102_0304, 0, 32'h0,        2, 0);
    issue("lb",   0, LB,  WB_MEM, 5'd10, 1, 32'h0000_0102, 32'h0,        0, 1, 32'h0080_FF00, 1, 4'h0,    32'h0,        1, 32'hFFFF_FF80, 1, 0);
    issue("lbu",  0, LBU, WB_MEM, 5'd11, 1, 32'h0000_0102, 32'h0,        0, 1, 32'h0080_FF00, 1, 4'h0,    32'h0,        1, 32'h0000_0080, 1, 0);
    issue("lh",   0, LH,  WB_MEM, 5'd12, 1, 32'h0000_0102, 32'h0,        0, 1, 32'h8001_0000, 1, 4'h0,    32'h0,        1, 32'hFFFF_8001, 1, 0);
    issue("lhu",  0, LHU, WB_MEM, 5'd13, 1, 32'h0000_0100, 32'h0,        0, 1, 32'h1234_9ABC, 1, 4'h0,    32'h0,        1, 32'h0000_9ABC, 1, 0);
    issue("lw_s", 0, LW,  WB_MEM, 5'd14, 1, 32'h0000_0200, 32'h0,        3, 2, 32'hCAFE_F00D, 1, 4'h0,    32'h0,        1, 32'hCAFE_F00D, 5, 0);
    issue("lh_mis", 0, LH, WB_MEM, 5'd15, 1, 32'h0000_0101, 32'h0,       0, 0, 32'h0,        0, 4'h0,    32'h0,        0, 32'h0,        0, 1);
    issue("sw_mis", 1, SW, WB_ALU, 5'd0, 0, 32'h0000_0102, 32'h1111_2222, 0, 0, 32'h0,       0, 4'h0,    32'h0,        0, 32'h0,        0, 1);
    issue("ld_ill", 0, 3'b011, WB_MEM, 5'd16, 1, 32'h0000_0100, 32'h0,   0, 0, 32'h0,        0, 4'h0,    32'h0,        0, 32'h0,        0, 1);

    // Reset while a load waits for read data
    begin
      bus_t b;
      b.addr = 32'h0000_0300; b.we = 1'b0; b.strb = 4'h0; b.wdata = 32'h0;
      bus_q.push_back(b);
    end
    alu_in = 32'h0000_0300; rd_addr_in = 5'd7; reg_write_in = 1'b1;
    mem_write_in = 1'b0; funct3_in = LW; wb_mux_in = WB_MEM; dbus_ready = 1'b1;
    @(posedge clk); #1;
    dbus_ready = 1'b0;
    check("rst_pre_stall", 32'(stall), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_valid", 32'(dbus_valid), 32'd0);
    check("rst_reg_write", 32'(reg_write_out), 32'd0);
    check("rst_alu_out", alu_out, 32'd0);
    check("rst_rd_addr", 32'(rd_addr_out), 32'd0);
    @(posedge clk); #1;
    drive_nop();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    dbus_rvalid = 1'b1; dbus_rdata = 32'hBAD0_BAD0;
    @(posedge clk); #1;
    dbus_rvalid = 1'b0;
    @(negedge clk);
    check("stray_rvalid_stall", 32'(stall), 32'd0);
    check("stray_rvalid_data", load_data_out, 32'd0);
    check("stray_rvalid_rw", 32'(reg_write_out), 32'd0);
    @(posedge clk); #1;

    issue("lw_after", 0, LW, WB_MEM, 5'd7, 1, 32'h0000_0300, 32'h0, 0, 1, 32'h1357_9BDF, 1, 4'h0, 32'h0, 1, 32'h1357_9BDF, 1, 0);

    repeat (3) @(posedge clk);
    #1;
    check("wb_queue_drained", 32'(wb_q.size()), 32'd0);
    check("bus_queue_drained", 32'(bus_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
